// File: rtl/spi_flash_target_pkg.sv
// spi_flash_target_pkg: opcodes, address length and FSM state encoding shared by the SPI flash target.
package spi_flash_target_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP = 8'h02;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam int ADDR_BYTES = 3;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_RDID, ST_WRITE, ST_IGNORE} state_e;
endpackage

// File: rtl/spi_flash_target_if.sv
// spi_flash_target_if: SPI pins plus byte-memory port; slave is the flash target, master is the host/memory side.
interface spi_flash_target_if #(parameter int ADDR_W = 9);
  logic spi_csb, spi_sck, spi_sdi, spi_sdo, spi_sdoenb;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_re, mem_we, busy;
  logic [7:0] mem_rdata, mem_wdata;
  modport slave (
    input spi_csb, spi_sck, spi_sdi, mem_rdata,
    output spi_sdo, spi_sdoenb, mem_addr, mem_re, mem_we, mem_wdata, busy
  );
  modport master (
    output spi_csb, spi_sck, spi_sdi, mem_rdata,
    input spi_sdo, spi_sdoenb, mem_addr, mem_re, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronizes csb/sck/sdi into core_clk and derives sck rise/fall and csb fall/rise pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic core_clk,
  input  logic core_rstn,
  input  logic csb_i,
  input  logic sck_i,
  input  logic sdi_i,
  output logic sdi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_fall_o,
  output logic csb_rise_o
);
  logic [SYNC_STAGES-1:0] csb_q, sck_q, sdi_q;
  logic csb_p_q, sck_p_q;
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      csb_q <= '1;
      sck_q <= '0;
      sdi_q <= '0;
      csb_p_q <= 1'b1;
      sck_p_q <= 1'b0;
    end else begin
      csb_q <= {csb_q[SYNC_STAGES-2:0], csb_i};
      sck_q <= {sck_q[SYNC_STAGES-2:0], sck_i};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
      csb_p_q <= csb_q[SYNC_STAGES-1];
      sck_p_q <= sck_q[SYNC_STAGES-1];
    end
  end
  assign sdi_o = sdi_q[SYNC_STAGES-1];
  assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_p_q;
  assign sck_fall_o = ~sck_q[SYNC_STAGES-1] & sck_p_q;
  assign csb_fall_o = ~csb_q[SYNC_STAGES-1] & csb_p_q;
  assign csb_rise_o = csb_q[SYNC_STAGES-1] & ~csb_p_q;
endmodule

// File: rtl/spi_flash_target.sv
// spi_flash_target: SPI mode-0 flash target serving READ/RDID from a byte memory port.
// Page program (0x02) is compiled in with SPI_FLASH_TARGET_WRITE_EN.
module spi_flash_target
  import spi_flash_target_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int SYNC_STAGES = 2
) (
  input logic core_clk,
  input logic core_rstn,
  spi_flash_target_if.slave bus
);
`ifdef SPI_FLASH_TARGET_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_CMD = ST_CMD;
  localparam logic [2:0] S_ADDR = ST_ADDR;
  localparam logic [2:0] S_READ = ST_READ;
  localparam logic [2:0] S_RDID = ST_RDID;
  localparam logic [2:0] S_WRITE = ST_WRITE;
  localparam logic [2:0] S_IGNORE = ST_IGNORE;
  logic sdi_s, sck_rise, sck_fall, csb_fall, csb_rise;
  logic [2:0] state_q, state_d, cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] tx_q, tx_d, wdata_q, wdata_d, rx, tx_cur;
  logic [1:0] bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wr_q, wr_d, re_q, re_d, ld_q, we_q, we_d, sdo_q, sdo_d, busy_q, busy_d, done;
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .core_clk(core_clk),
    .core_rstn(core_rstn),
    .csb_i(bus.spi_csb),
    .sck_i(bus.spi_sck),
    .sdi_i(bus.spi_sdi),
    .sdi_o(sdi_s),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .csb_fall_o(csb_fall),
    .csb_rise_o(csb_rise)
  );
  assign rx = {sh_q, sdi_s};
  assign done = sck_rise && cnt_q == 3'd7;
  // Read data lands a cycle after mem_re; use it directly so a fast fall still sees the new byte.
  assign tx_cur = ld_q ? bus.mem_rdata : tx_q;
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    bcnt_d = bcnt_q;
    addr_d = addr_q;
    wr_d = wr_q;
    re_d = 1'b0;
    we_d = 1'b0;
    wdata_d = wdata_q;
    sdo_d = sdo_q;
    busy_d = busy_q;
    tx_d = tx_cur;
    if (sck_rise) begin
      sh_d = rx[6:0];
      cnt_d = cnt_q + 3'd1;
    end
    if (sck_fall && (state_q == S_READ || state_q == S_RDID)) begin
      sdo_d = tx_cur[7];
      tx_d = {tx_cur[6:0], 1'b0};
    end
    if (we_q) addr_d = addr_q + ADDR_W'(1);
    case (state_q)
      S_IDLE: if (csb_fall) begin
        state_d = S_CMD;
        cnt_d = '0;
        busy_d = 1'b1;
      end
      S_CMD: if (done) begin
        bcnt_d = '0;
        wr_d = rx == OP_PP;
        tx_d = JEDEC_ID[23:16];
        state_d = rx == OP_READ || (WR_EN && rx == OP_PP) ? S_ADDR : rx == OP_RDID ? S_RDID : S_IGNORE;
      end
      S_ADDR: if (done) begin
        addr_d = ADDR_W'({addr_q, rx});
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'(ADDR_BYTES - 1)) begin
          state_d = wr_q ? S_WRITE : S_READ;
          re_d = !wr_q;
        end
      end
      S_READ: if (done) begin
        addr_d = addr_q + ADDR_W'(1);
        re_d = 1'b1;
      end
      S_RDID: if (done) begin
        bcnt_d = bcnt_q + {1'b0, bcnt_q != 2'd3};
        tx_d = bcnt_q == 2'd0 ? JEDEC_ID[15:8] : bcnt_q == 2'd1 ? JEDEC_ID[7:0] : 8'h00;
      end
      S_WRITE: if (done) begin
        we_d = 1'b1;
        wdata_d = rx;
      end
      default: ;
    endcase
    if (csb_rise) begin
      state_d = S_IDLE;
      sdo_d = 1'b0;
      busy_d = 1'b0;
      re_d = 1'b0;
      we_d = 1'b0;
    end
  end
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state_q <= S_IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      bcnt_q <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      re_q <= 1'b0;
      ld_q <= 1'b0;
      we_q <= 1'b0;
      wdata_q <= '0;
      sdo_q <= 1'b0;
      busy_q <= 1'b0;
      tx_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      re_q <= re_d;
      ld_q <= re_q;
      we_q <= we_d;
      wdata_q <= wdata_d;
      sdo_q <= sdo_d;
      busy_q <= busy_d;
      tx_q <= tx_d;
    end
  end
  assign bus.spi_sdo = sdo_q;
  assign bus.spi_sdoenb = !(state_q == S_READ || state_q == S_RDID);
  assign bus.mem_addr = addr_q;
  assign bus.mem_re = re_q;
  assign bus.mem_we = WR_EN && we_q;
  assign bus.mem_wdata = WR_EN ? wdata_q : 8'h00;
  assign bus.busy = busy_q;
endmodule

// File: doc/spi_flash_target.md
Name: spi_flash_target

Overview:
- Synthesizable SPI target (mode 0) that answers the housekeeping/mgmt SPI master on the mprj_io pins: csb=mprj_io[33], sck=mprj_io[32], sdi=mprj_io[35], sdo=mprj_io[34].
- Sits directly downstream of the SPI master and replaces the behavioural flash model with real RTL.
- Oversamples SPI pins in the core clock domain, decodes a flash-style command subset and serves bytes from a memory port.

Parameters:
- ADDR_W, 9, memory word-address width (byte-addressed, 512 bytes).
- JEDEC_ID, 24'hEF4016, value returned by RDID, MSB first.
- SYNC_STAGES, 2, synchronizer depth on csb/sck/sdi.

Ports:
- core_clk  input  1  core clock; must be at least 4x sck frequency.
- core_rstn  input  1  reset, synchronous, active-low.
- spi_csb  input  1  chip select, active-low.
- spi_sck  input  1  SPI clock.
- spi_sdi  input  1  MOSI.
- spi_sdo  output  1  MISO.
- spi_sdoenb  output  1  MISO output enable, active-low.
- mem_addr  output  ADDR_W  memory byte address.
- mem_re  output  1  read strobe; mem_rdata is valid on the following cycle.
- mem_rdata  input  8  read data.
- mem_we  output  1  write strobe (write feature only; tied 0 otherwise).
- mem_wdata  output  8  write data.
- busy  output  1  high while csb is low (synchronized).

Behaviour:
- Reset values: spi_sdo=0, spi_sdoenb=1, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0; FSM=IDLE.
- Pin sampling: csb, sck and sdi each pass through SYNC_STAGES flops. rise/fall pulses are derived from synchronized sck. sdi is sampled on rise. sdo changes on fall.
- Shift register: 8 bits, MSB first, with a 3-bit bit counter. A byte completes on the 8th rise.
- FSM states: IDLE, CMD, ADDR, READ, RDID, WRITE, IGNORE.
  - IDLE to CMD: falling edge of synchronized csb. bit counter=0, busy=1.
  - CMD, on byte complete:
    - 0x03 goes to ADDR with read flag set.
    - 0x02 goes to ADDR with write flag set (only when the write feature is compiled in).
    - 0x9F goes to RDID.
    - Any other opcode goes to IGNORE.
  - ADDR: collects 3 bytes (24-bit address); the low ADDR_W bits are kept.
    - After the 3rd byte, read: set mem_addr, pulse mem_re for 1 cycle, latch mem_rdata into tx_byte the next cycle, go to READ.
    - After the 3rd byte, write: go to WRITE.
  - READ:
    - Drive tx_byte[7] onto sdo, starting on the first fall after the address byte.
    - On each subsequent fall, shift tx_byte left.
    - On the 8th rise of each byte: increment mem_addr (wraps modulo 2^ADDR_W) and issue mem_re. The next tx_byte is therefore loaded before the next fall.
  - RDID: shifts out JEDEC_ID in 3 bytes. After the 3rd byte, sdo=0.
  - IGNORE: sdoenb=1 until csb goes high.
- spi_sdoenb=0 only in READ and RDID.
- csb rising (synchronized) in any state: go to IDLE the same cycle, sdoenb=1, sdo=0, busy=0. A partial byte is discarded and no mem_we is issued for it.
- Reset asserted mid-transfer: all outputs return to their reset values on the next core_clk edge.
- Simultaneous csb rise and byte completion: csb wins; the byte is dropped.

Optional Feature:
- Macro: SPI_FLASH_TARGET_WRITE_EN.
- With the macro defined:
  - Opcode 0x02 is accepted.
  - In WRITE, each completed byte drives mem_wdata and pulses mem_we for one cycle at mem_addr, then mem_addr increments with wrap.
- Without the macro: 0x02 goes to IGNORE, mem_we is constant 0 and mem_wdata is constant 0.

Decomposition:
- Package spi_flash_target_pkg:
  - Opcode constants OP_READ=8'h03, OP_PP=8'h02, OP_RDID=8'h9F.
  - FSM state enum.
  - ADDR_BYTES=3.
- One sub-module, spi_pin_sync: SYNC_STAGES synchronizer for csb/sck/sdi plus sck rise/fall and csb fall/rise pulse generation.

Test Plan:
- Read basic: preload mem[0..3]=93,01,00,13; send csb low, 03 00 00 00, then clock 4 bytes -> MISO returns 0x93,0x01,0x00,0x13; sdoenb=0 only during the data phase.
- Read wrap (ADDR_W=9): preload mem[0x1FF]=0xB5 and mem[0x000]=0x63; send 03 00 01 FF, read 2 bytes -> returns 0xB5 then 0x63.
- RDID: send 9F, read 4 bytes -> returns 0xEF,0x40,0x16, then 0x00.
- Unknown opcode and abort:
  - Send 0xAB, clock 8 more bits -> sdoenb stays 1.
  - Raise csb after 5 bits of an address byte, then send 03 00 00 00 -> transfer decodes correctly (no stale bits).
- Write (with SPI_FLASH_TARGET_WRITE_EN): send 02 00 00 10, 57, 23 -> mem_we pulses twice, writing 0x57 to 0x010 and 0x23 to 0x011. Without the macro, mem_we never asserts.
- Reset mid-read: assert core_rstn=0 for 1 cycle during the 2nd data byte -> next cycle sdoenb=1, sdo=0, mem_re=0, busy=0.
